// File: rtl/apb3_completer_pkg.sv
// Shared types and constants for the APB3 register-bank completer.
package apb3_completer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B3_0001;
  localparam int          WAIT_W           = 4;

endpackage

// File: rtl/apb3_regfile.sv
// Register storage: one write port, one combinational read port; index 0 is a constant ID.
// Writes land on the clock edge; reads settle in the same cycle. Writes to index 0 are dropped.
module apb3_regfile import apb3_completer_pkg::*; #(
  parameter int                   RegCount  = 16,
  parameter int                   DataWidth = 32,
  parameter logic [DataWidth-1:0] IdValue   = ID_VALUE_DEFAULT,
  localparam int                  IdxW      = $clog2(RegCount)
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 wr_en,
  input  logic [IdxW-1:0]      wr_idx,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [IdxW-1:0]      rd_idx,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] regs_q [RegCount];
  logic [DataWidth-1:0] regs_d [RegCount];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_idx != '0)) begin
      regs_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < RegCount; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_data = (rd_idx == '0) ? IdValue : regs_q[rd_idx];

endmodule

// File: rtl/apb3_completer_regs.sv
// APB3 completer over a register bank; response after WaitStates stalled access cycles.
// pready is held low while the wait counter drains; dropping pselx mid-access abandons the transfer.
module apb3_completer_regs import apb3_completer_pkg::*; #(
  parameter int                   AddressWidth = 20,
  parameter int                   DataWidth    = 32,
  parameter int                   RegCount     = 16,
  parameter int                   WaitStates   = 1,
  parameter logic [DataWidth-1:0] IdValue      = ID_VALUE_DEFAULT
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [AddressWidth-1:0] paddr,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DataWidth-1:0]    pwdata,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int IdxW = $clog2(RegCount);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;

  logic                 setup;
  logic                 addr_err;
  logic                 complete;
  logic                 wr_en;
  logic [DataWidth-1:0] rd_data;

  assign setup    = pselx && !penable;
  // Any set bit above the index field means the word address is past the bank.
  assign addr_err = (paddr[1:0] != 2'b00) || (|(paddr >> (IdxW + 2)));
  assign pready   = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign complete = pready && pselx && penable;
  assign wr_en    = complete && wr_q && !err_q;
  assign pslverr  = pready && err_q;
  assign prdata   = (pready && !wr_q && !err_q) ? rd_data : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_W'(WaitStates);
          idx_d   = paddr[IdxW+1:2];
          wr_d    = pwrite;
          err_d   = addr_err || (pwrite && (paddr[IdxW+1:2] == '0));
        end
      end
      ST_ACCESS: begin
        if (!pselx || complete) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  apb3_regfile #(
    .RegCount (RegCount),
    .DataWidth(DataWidth),
    .IdValue  (IdValue)
  ) u_regfile (
    .pclk   (pclk),
    .presetn(presetn),
    .wr_en  (wr_en),
    .wr_idx (idx_q),
    .wr_data(pwdata),
    .rd_idx (idx_q),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_apb3_completer_regs.sv
// Bench: three completers (WaitStates 1, 0, 15) driven by randomized APB3 transfers
// and compared against an array-based register model.
module tb_apb3_completer_regs;

  localparam int          NDUT = 3;
  localparam logic [31:0] ID   = 32'hA9B3_0001;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [19:0] paddr   [NDUT];
  logic        pselx   [NDUT];
  logic        penable [NDUT];
  logic        pwrite  [NDUT];
  logic [31:0] pwdata  [NDUT];
  logic [31:0] prdata  [NDUT];
  logic        pready  [NDUT];
  logic        pslverr [NDUT];

  logic [31:0] model [NDUT][16];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb3_completer_regs #(
      .WaitStates((g == 0) ? 1 : ((g == 1) ? 0 : 15))
    ) u_dut (
      .pclk   (pclk),
      .presetn(presetn),
      .paddr  (paddr[g]),
      .pselx  (pselx[g]),
      .penable(penable[g]),
      .pwrite (pwrite[g]),
      .pwdata (pwdata[g]),
      .prdata (prdata[g]),
      .pready (pready[g]),
      .pslverr(pslverr[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < 16; i++) model[k][i] = '0;
  endtask

  // Setup phase on the next negedge, then access phase until pready (bounded).
  task automatic xfer(input int k, input bit wr, input logic [19:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat);
    @(negedge pclk);
    pselx[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wd;
    @(negedge pclk);
    penable[k] = 1'b1;
    lat = 1;
    while (pready[k] !== 1'b1 && lat < 40) begin
      @(negedge pclk);
      lat++;
    end
    rd  = prdata[k];
    err = pslverr[k];
  endtask

  task automatic idle(input int k);
    @(negedge pclk);
    pselx[k] = 1'b0; penable[k] = 1'b0;
    check($sformatf("d%0d_pready_one_cycle", k), 32'(pready[k]), 32'd0);
  endtask

  task automatic checked_xfer(input int k, input bit wr, input logic [19:0] addr, input logic [31:0] wd);
    logic [31:0] rd, exp_rd;
    logic        err, exp_err;
    int          lat, idx;
    idx     = int'(addr) / 4;
    exp_err = (addr % 4 != 0) || (idx >= 16) || (wr && idx == 0);
    if (wr || exp_err)  exp_rd = '0;
    else if (idx == 0)  exp_rd = ID;
    else                exp_rd = model[k][idx];
    xfer(k, wr, addr, wd, rd, err, lat);
    check($sformatf("d%0d_latency@%h", k, addr), 32'(lat), 32'(ws_of(k) + 1));
    check($sformatf("d%0d_pslverr@%h", k, addr), 32'(err), 32'(exp_err));
    check($sformatf("d%0d_prdata@%h", k, addr), rd, exp_rd);
    if (wr && !exp_err) model[k][idx] = wd;
  endtask

  task automatic abort_write(input int k, input logic [19:0] addr, input logic [31:0] wd);
    @(negedge pclk);
    pselx[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = 1'b1; paddr[k] = addr; pwdata[k] = wd;
    @(negedge pclk);
    penable[k] = 1'b1;
    check($sformatf("d%0d_abort_stall", k), 32'(pready[k]), 32'd0);
    @(negedge pclk);
    pselx[k] = 1'b0; penable[k] = 1'b0;
    @(negedge pclk);
    check($sformatf("d%0d_abort_idle", k), 32'(pready[k]), 32'd0);
  endtask

  function automatic logic [19:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 20'h0;
      1:       return 20'(($urandom_range(0, 15) << 2) | $urandom_range(1, 3));
      2:       return 20'($urandom_range(16, 262143) << 2);
      default: return 20'($urandom_range(0, 15) << 2);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    for (int k = 0; k < NDUT; k++) begin
      paddr[k] = '0; pselx[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0; pwdata[k] = '0;
    end
    clear_model();
    presetn = 1'b1;
    #1 presetn = 1'b0;
    repeat (3) @(negedge pclk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("d%0d_rst_pready", k), 32'(pready[k]), 32'd0);
      check($sformatf("d%0d_rst_pslverr", k), 32'(pslverr[k]), 32'd0);
      check($sformatf("d%0d_rst_prdata", k), prdata[k], 32'd0);
    end
    presetn = 1'b1;

    // Directed register and error-decode behaviour on the one-wait completer.
    checked_xfer(0, 0, 20'h0, '0);
    idle(0);
    checked_xfer(0, 1, 20'h8, 32'hDEAD_BEEF);
    checked_xfer(0, 0, 20'h8, '0);
    checked_xfer(0, 0, 20'h4, '0);
    checked_xfer(0, 1, 20'h0, 32'h1234_5678);
    checked_xfer(0, 0, 20'h40, '0);
    checked_xfer(0, 0, 20'h6, '0);
    checked_xfer(0, 0, 20'h0, '0);
    idle(0);

    // Zero-wait and fifteen-wait builds.
    for (int k = 1; k < NDUT; k++) begin
      checked_xfer(k, 0, 20'h0, '0);
      checked_xfer(k, 1, 20'h3C, 32'hCAFE_F00D);
      checked_xfer(k, 0, 20'h3C, '0);
      idle(k);
    end

    // Abandoned writes must not commit.
    abort_write(0, 20'hC, 32'hA5A5_5A5A);
    checked_xfer(0, 0, 20'hC, '0);
    idle(0);
    abort_write(2, 20'hC, 32'h0BAD_0BAD);
    checked_xfer(2, 0, 20'hC, '0);
    idle(2);

    for (int k = 0; k < NDUT; k++) begin
      for (int it = 0; it < 50; it++) begin
        checked_xfer(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        if ($urandom_range(0, 2) == 0) idle(k);
      end
      idle(k);
    end

    // Asynchronous reset in the middle of a read response.
    checked_xfer(0, 1, 20'h4, 32'h0000_0055);
    idle(0);
    xfer(0, 0, 20'h4, '0, rd, err, lat);
    check("rst_pre_prdata", rd, 32'h0000_0055);
    #1 presetn = 1'b0;
    #1;
    check("rst_async_pready", 32'(pready[0]), 32'd0);
    check("rst_async_prdata", prdata[0], 32'd0);
    check("rst_async_pslverr", 32'(pslverr[0]), 32'd0);
    @(negedge pclk);
    pselx[0] = 1'b0; penable[0] = 1'b0;
    presetn = 1'b1;
    clear_model();
    checked_xfer(0, 0, 20'h4, '0);
    checked_xfer(0, 0, 20'h8, '0);
    idle(0);
    checked_xfer(2, 0, 20'h3C, '0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
